// File: rtl/corelet_ctrl_if.sv
// Handshake and instruction bundle between the layer sequencer and the corelet/top level.
// master: sequencer side; slave: start control and corelet side.
interface corelet_ctrl_if;
    logic        start;
    logic        ofifo_valid;
    logic [33:0] inst;
    logic        busy;
    logic        done;

    modport master (input start, input ofifo_valid, output inst, output busy, output done);
    modport slave  (output start, output ofifo_valid, input inst, input busy, input done);
endinterface

// File: rtl/corelet_ctrl.sv
// Per-layer instruction sequencer: weight fetch/load, activation fetch/execute, output drain
// to pmem for every kernel position, then one accumulate sweep over all partial sums.
module corelet_ctrl #(
    parameter int          ROW     = 8,
    parameter int          COL     = 8,
    parameter int          LEN_KIJ = 9,
    parameter int          LEN_NIJ = 36,
    parameter logic [10:0] W_BASE  = 11'd1024,
    parameter logic [10:0] X_BASE  = 11'd0,
    parameter int          DRAIN   = ROW + COL
) (
    input  logic           clk_i,
    input  logic           rst_i,
    corelet_ctrl_if.master bus
);
    localparam int          ACC_RD    = LEN_NIJ * LEN_KIJ;
    localparam logic [33:0] IDLE_WORD = 34'h1_800C_0000;

    typedef enum logic [3:0] {
        IDLE, W_FETCH, W_LOAD, W_DRAIN, A_FETCH, A_EXEC, A_DRAIN, O_READ, ACC, DONE
    } state_t;
    typedef logic [15:0] cnt_t;
    typedef logic [7:0]  idx_t;

    state_t      state_q, state_d;
    cnt_t        cnt_q, cnt_d, o_q, o_d, o_cur;
    idx_t        kij_q, kij_d, k_q, k_d, n_q, n_d;
    logic        rd_d;
    logic [33:0] inst_q, inst_d;

    // state_q/cnt_q always describe the word currently held in inst_q
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            o_q     <= '0;
            kij_q   <= '0;
            k_q     <= '0;
            n_q     <= '0;
            inst_q  <= IDLE_WORD;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            o_q     <= o_d;
            kij_q   <= kij_d;
            k_q     <= k_d;
            n_q     <= n_d;
            inst_q  <= inst_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        o_d     = o_q;
        o_cur   = o_q;
        kij_d   = kij_q;
        k_d     = k_q;
        n_d     = n_q;
        rd_d    = 1'b0;
        case (state_q)
            IDLE: if (bus.start) begin
                state_d = W_FETCH;
                cnt_d   = '0;
                kij_d   = '0;
            end
            W_FETCH: if (cnt_q == cnt_t'(COL)) begin
                state_d = W_LOAD;
                cnt_d   = '0;
            end else cnt_d = cnt_q + cnt_t'(1);
            W_LOAD: if (cnt_q == cnt_t'(COL - 1)) begin
                state_d = W_DRAIN;
                cnt_d   = '0;
            end else cnt_d = cnt_q + cnt_t'(1);
            W_DRAIN: if (cnt_q == cnt_t'(DRAIN - 1)) begin
                state_d = A_FETCH;
                cnt_d   = '0;
            end else cnt_d = cnt_q + cnt_t'(1);
            A_FETCH: if (cnt_q == cnt_t'(LEN_NIJ)) begin
                state_d = A_EXEC;
                cnt_d   = '0;
            end else cnt_d = cnt_q + cnt_t'(1);
            A_EXEC: if (cnt_q == cnt_t'(LEN_NIJ - 1)) begin
                state_d = A_DRAIN;
                cnt_d   = '0;
            end else cnt_d = cnt_q + cnt_t'(1);
            A_DRAIN: if (cnt_q == cnt_t'(DRAIN - 1)) begin
                state_d = O_READ;
                o_cur   = '0;
                rd_d    = bus.ofifo_valid;
                o_d     = cnt_t'(rd_d);
            end else cnt_d = cnt_q + cnt_t'(1);
            O_READ: if (o_q == cnt_t'(LEN_NIJ)) begin
                cnt_d = '0;
                o_d   = '0;
                if (kij_q == idx_t'(LEN_KIJ - 1)) begin
                    state_d = ACC;
                    k_d     = '0;
                    n_d     = '0;
                end else begin
                    state_d = W_FETCH;
                    kij_d   = kij_q + idx_t'(1);
                end
            end else begin
                rd_d = bus.ofifo_valid;
                o_d  = o_q + cnt_t'(rd_d);
            end
            ACC: if (cnt_q == cnt_t'(ACC_RD)) begin
                state_d = DONE;
            end else begin
                cnt_d = cnt_q + cnt_t'(1);
                if (k_q == idx_t'(LEN_KIJ - 1)) begin
                    k_d = '0;
                    n_d = n_q + idx_t'(1);
                end else k_d = k_q + idx_t'(1);
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Word for the state being entered; acc echoes the accumulate read now in inst_q
    always_comb begin
        inst_d     = IDLE_WORD;
        inst_d[33] = (state_q == ACC) && (cnt_q < cnt_t'(ACC_RD));
        case (state_d)
            W_FETCH: begin
                if (cnt_d < cnt_t'(COL)) begin
                    inst_d[19]   = 1'b0;
                    inst_d[17:7] = W_BASE + 11'(kij_d * COL) + 11'(cnt_d);
                end
                inst_d[2] = (cnt_d != '0);
            end
            W_LOAD: begin
                inst_d[3] = 1'b1;
                inst_d[0] = 1'b1;
            end
            A_FETCH: begin
                if (cnt_d < cnt_t'(LEN_NIJ)) begin
                    inst_d[19]   = 1'b0;
                    inst_d[17:7] = X_BASE + 11'(cnt_d);
                end
                inst_d[2] = (cnt_d != '0);
            end
            A_EXEC: begin
                inst_d[3] = 1'b1;
                inst_d[1] = 1'b1;
            end
            O_READ: if (rd_d) begin
                inst_d[6]     = 1'b1;
                inst_d[32]    = 1'b0;
                inst_d[31]    = 1'b0;
                inst_d[30:20] = 11'(kij_d * LEN_NIJ) + 11'(o_cur);
            end
            ACC: if (cnt_d < cnt_t'(ACC_RD)) begin
                inst_d[32]    = 1'b0;
                inst_d[30:20] = 11'(k_d * LEN_NIJ) + 11'(n_d);
            end
            default: ;
        endcase
    end

    assign bus.inst = inst_q;
    assign bus.busy = (state_q != IDLE);
    assign bus.done = (state_q == DONE);
endmodule

// File: tb/tb_corelet_ctrl.sv
// Directed bench for corelet_ctrl: checkpoint table over a full layer, then stall and
// mid-run reset sequences.
module tb_corelet_ctrl;
    localparam int          NC      = 1760;
    localparam int          KIJ_LEN = 158;   // 2*8 + 2*16 + 3*36 + 2
    localparam int          ACC_AT  = 1422;  // 9 * 158
    localparam int          DONE_AT = 1747;  // ACC_AT + 324 + 1
    localparam logic [33:0] IDLE_W  = 34'h1_800C_0000;
    localparam logic [6:0]  OFRD = 7'h40, L0RD = 7'h08, L0WR = 7'h04, EX = 7'h02, LD = 7'h01;

    typedef struct {
        string       name;
        int          cyc;
        logic [33:0] inst;
        logic        busy;
        logic        done;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    corelet_ctrl_if bus();
    corelet_ctrl dut (.clk_i(clk), .rst_i(rst), .bus(bus));

    always #5 clk = ~clk;

    vec_t        vq[$];
    logic [33:0] tr_inst [NC];
    logic        tr_busy [NC];
    logic        tr_done [NC];
    int          nvec = 0;
    int          nerr = 0;

    function automatic logic [33:0] mkw(input logic acc, input logic cenp, input logic wenp,
                                        input logic [10:0] ap, input logic cenx, input logic wenx,
                                        input logic [10:0] ax, input logic [6:0] ctl);
        return {acc, cenp, wenp, ap, cenx, wenx, ax, ctl};
    endfunction
    function automatic logic [33:0] xrd(input int ax, input logic [6:0] ctl);
        return mkw(1'b0, 1'b1, 1'b1, 11'd0, 1'b0, 1'b1, 11'(ax), ctl);
    endfunction
    function automatic logic [33:0] ctlw(input logic [6:0] ctl);
        return mkw(1'b0, 1'b1, 1'b1, 11'd0, 1'b1, 1'b1, 11'd0, ctl);
    endfunction
    function automatic logic [33:0] pwr(input int ap);
        return mkw(1'b0, 1'b0, 1'b0, 11'(ap), 1'b1, 1'b1, 11'd0, OFRD);
    endfunction
    function automatic logic [33:0] prd(input logic acc, input int ap);
        return mkw(acc, 1'b0, 1'b1, 11'(ap), 1'b1, 1'b1, 11'd0, 7'h00);
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic addv(input string nm, input int cyc, input logic [33:0] iw,
                        input logic b, input logic d);
        vec_t e;
        e.name = nm; e.cyc = cyc; e.inst = iw; e.busy = b; e.done = d;
        vq.push_back(e);
    endtask

    // Pulses start, then records the word seen in cycle c (c=0 is the first word after start).
    task automatic run_layer(input int ncyc, input int stall_at, input int xs0, input int xs1);
        @(negedge clk);
        bus.start = 1'b1;
        bus.ofifo_valid = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        for (int c = 0; c < ncyc; c++) begin
            tr_inst[c] = bus.inst;
            tr_busy[c] = bus.busy;
            tr_done[c] = bus.done;
            bus.ofifo_valid = !(stall_at >= 0 && c >= stall_at && c < stall_at + 5);
            bus.start = (c == xs0) || (c == xs1);
            if (c < ncyc - 1) @(negedge clk);
        end
        bus.start = 1'b0;
    endtask

    initial begin
        int n_acc, n_done, n_busy, n_ex, n_ovl, n_wr, n_wr_ok, n1, n1_ok;
        bus.start = 1'b0;
        bus.ofifo_valid = 1'b0;
        rst = 1'b1;

        addv("wf0_t0", 0, xrd(1024, 7'h00), 1'b1, 1'b0);
        addv("wf0_t1", 1, xrd(1025, L0WR), 1'b1, 1'b0);
        addv("wf0_t7", 7, xrd(1031, L0WR), 1'b1, 1'b0);
        addv("wf0_t8", 8, ctlw(L0WR), 1'b1, 1'b0);
        addv("wl0_first", 9, ctlw(L0RD | LD), 1'b1, 1'b0);
        addv("wl0_last", 16, ctlw(L0RD | LD), 1'b1, 1'b0);
        addv("wd0_first", 17, IDLE_W, 1'b1, 1'b0);
        addv("wd0_last", 32, IDLE_W, 1'b1, 1'b0);
        addv("af0_t0", 33, xrd(0, 7'h00), 1'b1, 1'b0);
        addv("af0_t35", 68, xrd(35, L0WR), 1'b1, 1'b0);
        addv("af0_t36", 69, ctlw(L0WR), 1'b1, 1'b0);
        addv("ax0_first", 70, ctlw(L0RD | EX), 1'b1, 1'b0);
        addv("ax0_last", 105, ctlw(L0RD | EX), 1'b1, 1'b0);
        addv("ad0_first", 106, IDLE_W, 1'b1, 1'b0);
        addv("ad0_last", 121, IDLE_W, 1'b1, 1'b0);
        addv("or0_first", 122, pwr(0), 1'b1, 1'b0);
        addv("or0_last", 157, pwr(35), 1'b1, 1'b0);
        addv("wf1_t0", KIJ_LEN, xrd(1032, 7'h00), 1'b1, 1'b0);
        for (int t = 0; t < 8; t++)
            addv($sformatf("wf2_t%0d", t), 2 * KIJ_LEN + t,
                 xrd(1040 + t, (t == 0) ? 7'h00 : L0WR), 1'b1, 1'b0);
        addv("wf2_t8", 2 * KIJ_LEN + 8, ctlw(L0WR), 1'b1, 1'b0);
        for (int t = 0; t < 8; t++)
            addv($sformatf("wl2_t%0d", t), 2 * KIJ_LEN + 9 + t, ctlw(L0RD | LD), 1'b1, 1'b0);
        addv("wd2_first", 2 * KIJ_LEN + 17, IDLE_W, 1'b1, 1'b0);
        addv("ax2_first", 2 * KIJ_LEN + 70, ctlw(L0RD | EX), 1'b1, 1'b0);
        addv("ax2_last", 2 * KIJ_LEN + 105, ctlw(L0RD | EX), 1'b1, 1'b0);
        for (int t = 0; t < 16; t++)
            addv($sformatf("ad2_t%0d", t), 2 * KIJ_LEN + 106 + t, IDLE_W, 1'b1, 1'b0);
        addv("or2_first", 2 * KIJ_LEN + 122, pwr(72), 1'b1, 1'b0);
        addv("kij3_after_start", 501, IDLE_W, 1'b1, 1'b0);
        addv("or8_last", ACC_AT - 1, pwr(323), 1'b1, 1'b0);
        addv("acc_trail", DONE_AT - 1, mkw(1'b1, 1'b1, 1'b1, 11'd0, 1'b1, 1'b1, 11'd0, 7'h00),
             1'b1, 1'b0);
        addv("done_cycle", DONE_AT, IDLE_W, 1'b1, 1'b1);
        addv("after_done", DONE_AT + 1, IDLE_W, 1'b0, 1'b0);
        addv("idle_tail", NC - 1, IDLE_W, 1'b0, 1'b0);

        repeat (3) @(negedge clk);
        chk("reset_inst", bus.inst, IDLE_W);
        chk("reset_busy", bus.busy, 0);
        chk("reset_done", bus.done, 0);
        rst = 1'b0;

        // Full layer, ofifo_valid held high, stray starts mid-run and in the DONE cycle
        run_layer(NC, -1, 500, DONE_AT);
        foreach (vq[i])
            chk(vq[i].name, {tr_inst[vq[i].cyc], tr_busy[vq[i].cyc], tr_done[vq[i].cyc]},
                {vq[i].inst, vq[i].busy, vq[i].done});
        for (int i = 0; i < 324; i++)
            chk($sformatf("acc_rd%0d", i), tr_inst[ACC_AT + i], prd(i > 0, (i % 9) * 36 + i / 9));
        n_acc = 0; n_done = 0; n_busy = 0; n_ex = 0; n_ovl = 0; n_wr = 0; n_wr_ok = 0;
        for (int c = 0; c < NC; c++) begin
            if (tr_inst[c][33]) n_acc++;
            if (tr_done[c]) n_done++;
            if (tr_busy[c]) n_busy++;
            if (tr_inst[c][1] && tr_inst[c][3]) n_ex++;
            if (tr_inst[c][1] && tr_inst[c][0]) n_ovl++;
            if (tr_inst[c][6] && !tr_inst[c][32] && !tr_inst[c][31]) begin
                if (int'(tr_inst[c][30:20]) == n_wr) n_wr_ok++;
                n_wr++;
            end
        end
        chk("acc_pulses", n_acc, 324);
        chk("done_pulses", n_done, 1);
        chk("busy_cycles", n_busy, DONE_AT + 1);
        chk("exec_cycles", n_ex, 324);
        chk("exec_load_overlap", n_ovl, 0);
        chk("pmem_writes", n_wr, 324);
        chk("pmem_write_order", n_wr_ok, 324);

        // ofifo_valid low for 5 cycles after the 10th read of kij=1
        run_layer(NC, KIJ_LEN + 122 + 9, -1, -1);
        chk("stall_last_read", tr_inst[KIJ_LEN + 131], pwr(45));
        for (int t = 0; t < 5; t++)
            chk($sformatf("stall_idle%0d", t), tr_inst[KIJ_LEN + 132 + t], IDLE_W);
        chk("stall_resume", tr_inst[KIJ_LEN + 137], pwr(46));
        chk("stall_or1_last", tr_inst[KIJ_LEN + 162], pwr(71));
        chk("stall_wf2_t0", tr_inst[KIJ_LEN + 163], xrd(1040, 7'h00));
        chk("stall_done_at", {tr_done[DONE_AT + 4], tr_done[DONE_AT + 5]}, 2'b01);
        chk("stall_busy_end", {tr_busy[DONE_AT + 5], tr_busy[DONE_AT + 6]}, 2'b10);
        n1 = 0; n1_ok = 0;
        for (int c = 0; c < NC; c++)
            if (tr_inst[c][6] && !tr_inst[c][32] && !tr_inst[c][31] &&
                tr_inst[c][30:20] >= 11'd36 && tr_inst[c][30:20] <= 11'd71) begin
                if (int'(tr_inst[c][30:20]) == 36 + n1) n1_ok++;
                n1++;
            end
        chk("stall_kij1_writes", n1, 36);
        chk("stall_kij1_order", n1_ok, 36);

        // Reset in the middle of the kij=0 execute burst, then restart
        run_layer(81, -1, -1, -1);
        chk("pre_reset_exec", tr_inst[80], ctlw(L0RD | EX));
        #2 rst = 1'b1;
        #1;
        chk("async_reset_inst", bus.inst, IDLE_W);
        chk("async_reset_busy", bus.busy, 0);
        chk("async_reset_done", bus.done, 0);
        @(negedge clk);
        rst = 1'b0;
        run_layer(2, -1, -1, -1);
        chk("restart_t0", {tr_inst[0], tr_busy[0]}, {xrd(1024, 7'h00), 1'b1});
        chk("restart_t1", tr_inst[1], xrd(1025, L0WR));

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
